alu_byte_sequencer: RTL and testbench
=====================================

# alu_byte_sequencer

Multi-cycle controller that runs N-byte arithmetic and logic commands through the shared 8-bit ALU slice, one byte per clock, least-significant byte first. The inter-byte carry (the ALU carry-out) is registered and fed back as carry-in. It takes commands on a valid/ready handshake, drives the ALU operand, opcode and carry-in ports, and returns the assembled wide result with flags on a valid/ready response channel. It sits between the command source and the ALU datapath.

## Interface
- NBYTES, 2: operand width in bytes; W = 8*NBYTES; legal range 1..8.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR; 101–111 illegal.
- cmd_a, cmd_b  in  W  operands.
- alu_a, alu_b  out  8  byte operands to the ALU.
- alu_op  out  2  ALU function: 00 ADD (f=a+b+cin), 01 AND, 10 OR, 11 XOR.
- alu_cin  out  1  ALU carry-in.
- alu_f  in  8  ALU result, combinational from alu_* outputs.
- alu_cout  in  1  ALU carry-out; meaningful only for alu_op=00.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_f  out  W  result.
- rsp_cout  out  1  final carry; for SUB, 1 means no borrow.
- rsp_ovf  out  1  signed overflow (ADD/SUB only, else 0).
- rsp_zero  out  1  rsp_f == 0.
- rsp_err  out  1  command had an illegal opcode.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch op, A, B; clear byte index k and carry register; go to RUN.
- RUN:
  - Drive alu_a = A[8k+7:8k].
  - For SUB, drive alu_b = ~B byte. Otherwise drive alu_b = B byte.
  - alu_op: ADD/SUB→00, AND→01, OR→10, XOR→11.
  - alu_cin: k=0 gives 1 for SUB and 0 otherwise. k>0 gives the carry register (ADD/SUB) or 0 (logic ops).
  - Each edge: store alu_f into result byte k. Store alu_cout into the carry register (forced 0 for logic ops). Increment k.
  - After the edge with k=NBYTES-1, go to DONE.
- DONE:
  - rsp_valid=1; rsp_* stable.
  - On rsp_ready: go to IDLE.
- Flags, computed on the final RUN edge:
  - rsp_cout = final carry.
  - rsp_ovf = (sA==sB')&(sR!=sA), where s* are the W-1 bits and B' is B (ADD) or ~B (SUB).
  - rsp_zero from the full result.
- Illegal opcode: the command is still accepted and the same sequence runs with alu_op=00 and all alu_a/alu_b/alu_cin = 0. Response is rsp_f=0, rsp_cout=0, rsp_ovf=0, rsp_zero=1, rsp_err=1.
- In IDLE and DONE: alu_a, alu_b, alu_op, alu_cin are driven 0.
- cmd_ready is 0 in RUN and DONE. No command is accepted in the cycle rsp handshakes.
- Reset (any time, including mid-RUN):
  - state=IDLE.
  - cmd_ready=0, then 1 from the first rising edge with rst low.
  - rsp_valid=0; rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_err=0; alu_* = 0.
  - An in-flight command is discarded and never responded to.

## Timing
- Command accepted at edge E0 (cmd_valid & cmd_ready).
- ALU byte k is driven in the cycle after edge E0+k; result byte captured at edge E0+k+1.
- rsp_valid rises after edge E0+NBYTES. Latency NBYTES+1 cycles; NBYTES=2 gives 3.
- Response handshake at edge Ed (rsp_valid & rsp_ready). cmd_ready=1 after Ed; the earliest next accept is edge Ed+1.
- Peak throughput: one command per NBYTES+2 cycles.
- rsp_* are registered and hold while rsp_valid & ~rsp_ready.
- cmd_* inputs are sampled only at the accept edge. Changes afterwards are ignored.

## Test plan
- Carry propagation (NBYTES=2): ADD 0x12FF + 0x0001.
  - ALU cycle 1: alu_cin=0. ALU cycle 2: alu_cin=1.
  - Response: rsp_f=0x1300, cout=0, ovf=0, zero=0.
  - rsp_valid rises 3 cycles after accept.
- SUB cases:
  - 0x0000-0x0001 → rsp_f=0xFFFF, cout=0, ovf=0.
  - 0x8000-0x0001 → rsp_f=0x7FFF, cout=1, ovf=1.
- Logic ops:
  - XOR 0xA5A5^0xA5A5 → rsp_f=0x0000, zero=1, cout=0, alu_cin=0 throughout.
  - OR 0x00F0|0x0F00 → rsp_f=0x0FF0.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp_* stable, cmd_ready=0.
  - Second command accepted exactly one edge after the rsp handshake.
- Reset mid-RUN:
  - Assert rst during the byte-0 cycle → all outputs 0 immediately (asynchronous).
  - No rsp_valid ever appears for that command; cmd_ready=1 one edge after release.
- Illegal op 3'b111 with A=0xFFFF:
  - Response: rsp_err=1, rsp_f=0, zero=1, cout=0, ovf=0.
  - Latency still 3 cycles.

Source files
------------

// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: runs N-byte ALU commands through an 8-bit slice,
// one byte per clock, LSB first, with a registered inter-byte carry.
module alu_byte_sequencer #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [8*NBYTES-1:0]   cmd_a,
  input  logic [8*NBYTES-1:0]   cmd_b,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [1:0]            alu_op,
  output logic                  alu_cin,
  input  logic [7:0]            alu_f,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_f,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic           rdy_q;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [KW-1:0]  k_q;
  logic           carry_q;
  logic [W-1:0]   res_q;

  logic [W-1:0]   rsp_f_q;
  logic           rsp_cout_q;
  logic           rsp_ovf_q;
  logic           rsp_zero_q;
  logic           rsp_err_q;

  logic           is_add;
  logic           is_sub;
  logic           is_and;
  logic           is_or;
  logic           is_xor;
  logic           legal;
  logic           arith;

  logic           accept;
  logic           last;
  logic [KW+2:0]  bit_sh;
  logic [W-1:0]   a_shift;
  logic [W-1:0]   b_shift;
  logic [7:0]     a_byte;
  logic [7:0]     b_byte;
  logic [W-1:0]   res_nxt;

  logic           sign_a;
  logic           sign_b;
  logic           sign_r;
  logic           ovf_nxt;

  // handshake strobes
  assign accept    = (state == IDLE) & rdy_q & cmd_valid;
  assign last      = (k_q == KLAST);
  assign cmd_ready = (state == IDLE) & rdy_q;
  assign rsp_valid = (state == DONE);

  // decode the latched opcode
  always_comb begin
    is_add = 1'b0;
    is_sub = 1'b0;
    is_and = 1'b0;
    is_or  = 1'b0;
    is_xor = 1'b0;
    case (op_q)
      3'b000:  is_add = 1'b1;
      3'b001:  is_sub = 1'b1;
      3'b010:  is_and = 1'b1;
      3'b011:  is_or  = 1'b1;
      3'b100:  is_xor = 1'b1;
      default: ;
    endcase
  end

  assign legal = is_add | is_sub | is_and | is_or | is_xor;
  assign arith = is_add | is_sub;

  // current byte lane of each operand
  assign bit_sh  = {k_q, 3'b000};
  assign a_shift = a_q >> bit_sh;
  assign b_shift = b_q >> bit_sh;
  assign a_byte  = a_shift[7:0];
  assign b_byte  = b_shift[7:0];

  // ALU port drive; all zero outside RUN and for illegal opcodes
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_op  = 2'b00;
    alu_cin = 1'b0;
    if (state == RUN && legal) begin
      alu_a = a_byte;
      alu_b = is_sub ? ~b_byte : b_byte;
      unique case (1'b1)
        is_and:  alu_op = 2'b01;
        is_or:   alu_op = 2'b10;
        is_xor:  alu_op = 2'b11;
        default: alu_op = 2'b00;
      endcase
      if (arith) begin
        alu_cin = (k_q == '0) ? is_sub : carry_q;
      end
    end
  end

  // merge the ALU byte into the partial result
  always_comb begin
    res_nxt = res_q & ~(W'(8'hFF) << bit_sh);
    res_nxt = res_nxt | (W'(alu_f) << bit_sh);
  end

  // signed overflow seen on the final byte
  assign sign_a  = a_q[W-1];
  assign sign_b  = is_sub ? ~b_q[W-1] : b_q[W-1];
  assign sign_r  = res_nxt[W-1];
  assign ovf_nxt = arith & (sign_a == sign_b) & (sign_r != sign_a);

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // state register and post-reset ready enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= 1'b1;
    end
  end

  // command capture and per-byte sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      a_q     <= cmd_a;
      b_q     <= cmd_b;
      k_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else if (state == RUN) begin
      res_q   <= res_nxt;
      carry_q <= arith & alu_cout;
      k_q     <= last ? '0 : k_q + KW'(1);
    end
  end

  // response registers, loaded on the final byte edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_f_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (state == RUN && last) begin
      rsp_f_q    <= legal ? res_nxt : '0;
      rsp_cout_q <= arith & alu_cout;
      rsp_ovf_q  <= ovf_nxt;
      rsp_zero_q <= legal ? (res_nxt == '0) : 1'b1;
      rsp_err_q  <= ~legal;
    end
  end

  assign rsp_f    = rsp_f_q;
  assign rsp_cout = rsp_cout_q;
  assign rsp_ovf  = rsp_ovf_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// tb_alu_byte_sequencer: transaction-level model plus per-cycle compare,
// directed corner cases and randomized traffic with backpressure.
module tb_alu_byte_sequencer;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [W-1:0]   cmd_a;
  logic [W-1:0]   cmd_b;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic [1:0]     alu_op;
  logic           alu_cin;
  logic [7:0]     alu_f;
  logic           alu_cout;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_f;
  logic           rsp_cout;
  logic           rsp_ovf;
  logic           rsp_zero;
  logic           rsp_err;

  alu_byte_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // the 8-bit ALU slice
  always_comb begin
    alu_f    = 8'h00;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      2'b01: alu_f = alu_a & alu_b;
      2'b10: alu_f = alu_a | alu_b;
      default: alu_f = alu_a ^ alu_b;
    endcase
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] f;
    logic         co;
    logic         ov;
    logic         z;
    logic         er;
  } rsp_t;

  // whole-word reference result
  function automatic rsp_t ref_rsp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    logic [W:0] s;
    logic [W-1:0] bp;
    bp = (op == 3'd1) ? ~b : b;
    case (op)
      3'd0: s = {1'b0, a} + {1'b0, b};
      3'd1: s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      3'd2: s = {1'b0, a & b};
      3'd3: s = {1'b0, a | b};
      3'd4: s = {1'b0, a ^ b};
      default: s = '0;
    endcase
    r.f  = s[W-1:0];
    r.co = s[W];
    r.er = (op > 3'd4);
    r.z  = (r.f == '0);
    r.ov = (op <= 3'd1) && (a[W-1] == bp[W-1]) && (r.f[W-1] != a[W-1]);
    return r;
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int k);
    return 8'(v >> (8 * k));
  endfunction

  // carry into byte k = bit 8k of the sum of the lower 8k bits
  function automatic logic exp_cin(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    logic [W:0] m;
    logic [W:0] s;
    logic [W-1:0] bp;
    if (op > 3'd1) return 1'b0;
    if (k == 0) return (op == 3'd1);
    bp = (op == 3'd1) ? ~b : b;
    m  = ((W+1)'(1) << (8 * k)) - (W+1)'(1);
    s  = ({1'b0, a} & m) + ({1'b0, bp} & m) + (W+1)'(op == 3'd1);
    return s[8 * k];
  endfunction

  // protocol-level model: 0 idle, 1 running byte m_k, 2 response held
  int           m_mode;
  int           m_k;
  bit           m_rdy;
  int           m_rsp_cnt = 0;
  logic [2:0]   m_op;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  rsp_t         e_rsp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_k    = 0;
      m_rdy  = 0;
      e_rsp  = '0;
    end else begin
      case (m_mode)
        0: if (m_rdy && cmd_valid) begin
             m_op = cmd_op; m_a = cmd_a; m_b = cmd_b;
             m_k = 0; m_mode = 1;
           end
        1: if (m_k == NB - 1) begin
             e_rsp = ref_rsp(m_op, m_a, m_b);
             m_mode = 2;
           end else begin
             m_k++;
           end
        default: if (rsp_ready) begin
             m_mode = 0;
             m_rsp_cnt++;
           end
      endcase
      m_rdy = 1;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic       legal;
    logic [7:0] ea, eb;
    logic [1:0] eop;
    logic       ec;
    ea = 0; eb = 0; eop = 0; ec = 0;
    chk("cmd_ready", cmd_ready, (m_mode == 0) && m_rdy);
    chk("rsp_valid", rsp_valid, m_mode == 2);
    if (m_mode == 2 || rst) begin
      chk("rsp_f", rsp_f, e_rsp.f);
      chk("rsp_cout", rsp_cout, e_rsp.co);
      chk("rsp_ovf", rsp_ovf, e_rsp.ov);
      chk("rsp_zero", rsp_zero, e_rsp.z);
      chk("rsp_err", rsp_err, e_rsp.er);
    end
    if (m_mode == 1 && !rst) begin
      legal = (m_op <= 3'd4);
      if (legal) begin
        ea  = byte_of(m_a, m_k);
        eb  = byte_of((m_op == 3'd1) ? ~m_b : m_b, m_k);
        eop = (m_op <= 3'd1) ? 2'd0 : 2'(m_op - 3'd1);
        ec  = exp_cin(m_op, m_a, m_b, m_k);
      end
    end
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_op", alu_op, eop);
    chk("alu_cin", alu_cin, ec);
  end

  logic [1:0] cin_log;

  task automatic do_accept();
    bit hs;
    hs = 0;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk);
      #2;
    end
    if (!hs) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int lat);
    bit got;
    got = 0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat <= 2) cin_log[lat-1] = alu_cin;
      got = rsp_valid;
    end
    if (!got) chk("rsp_timeout", 0, 1);
  endtask

  task automatic release_rsp();
    rsp_ready = 1;
    @(posedge clk);
    #2;
    rsp_ready = 0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output rsp_t r, output int lat);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1;
    do_accept();
    cmd_valid = 0;
    cmd_op = 3'($urandom);
    cmd_a = W'($urandom);
    cmd_b = W'($urandom);
    wait_rsp(lat);
    r = '{f: rsp_f, co: rsp_cout, ov: rsp_ovf, z: rsp_zero, er: rsp_err};
    release_rsp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [W-1:0] corner [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h00FF};

  initial begin
    rsp_t r;
    int lat;

    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0;
    #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_f", rsp_f, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    @(negedge clk);
    chk("ready_before_edge", cmd_ready, 0);
    @(posedge clk);
    #2;

    r = ref_rsp(3'd0, 16'h12FF, 16'h0001);
    chk("model_add", r, {16'h1300, 4'b0000});
    r = ref_rsp(3'd1, 16'h8000, 16'h0001);
    chk("model_sub", r, {16'h7FFF, 4'b1100});

    run_cmd(3'd0, 16'h12FF, 16'h0001, r, lat);
    chk("add_f", r.f, 16'h1300);
    chk("add_flags", {r.co, r.ov, r.z, r.er}, 4'b0000);
    chk("add_lat", lat, 3);
    chk("add_cin", cin_log, 2'b10);

    run_cmd(3'd1, 16'h0000, 16'h0001, r, lat);
    chk("sub0_f", r.f, 16'hFFFF);
    chk("sub0_flags", {r.co, r.ov}, 2'b00);

    run_cmd(3'd1, 16'h8000, 16'h0001, r, lat);
    chk("sub1_f", r.f, 16'h7FFF);
    chk("sub1_flags", {r.co, r.ov}, 2'b11);

    run_cmd(3'd4, 16'hA5A5, 16'hA5A5, r, lat);
    chk("xor_f", r.f, 16'h0000);
    chk("xor_flags", {r.co, r.z}, 2'b01);
    chk("xor_cin", cin_log, 2'b00);

    run_cmd(3'd3, 16'h00F0, 16'h0F00, r, lat);
    chk("or_f", r.f, 16'h0FF0);

    run_cmd(3'd7, 16'hFFFF, 16'h1234, r, lat);
    chk("ill_f", r.f, 16'h0000);
    chk("ill_flags", {r.co, r.ov, r.z, r.er}, 4'b0011);
    chk("ill_lat", lat, 3);

    // backpressure with a second command waiting
    cmd_op = 3'd0; cmd_a = 16'h0102; cmd_b = 16'h0304; cmd_valid = 1;
    do_accept();
    cmd_op = 3'd2; cmd_a = 16'h3C5A; cmd_b = 16'h0FF0;
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_f", rsp_f, 16'h0406);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    release_rsp();
    @(negedge clk);
    chk("bp_ready_after", cmd_ready, 1);
    @(posedge clk);
    #2;
    cmd_valid = 0;
    @(negedge clk);
    chk("bp_second_byte0", alu_a, 8'h5A);
    chk("bp_second_op", alu_op, 2'b01);
    wait_rsp(lat);
    chk("bp_second_f", rsp_f, 16'h0C50);
    release_rsp();

    // reset during byte 0
    cmd_op = 3'd0; cmd_a = 16'h1234; cmd_b = 16'h1111; cmd_valid = 1;
    do_accept();
    cmd_valid = 0;
    #1;
    rst = 1;
    #1;
    chk("rst_outs", {cmd_ready, rsp_valid, alu_a, alu_b, alu_op, alu_cin}, 0);
    chk("rst_rsp", {rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_err}, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 0;
    @(negedge clk);
    chk("rst_ready_low", cmd_ready, 0);
    @(negedge clk);
    chk("rst_ready_high", cmd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk);
    #2;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cmd_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
      cmd_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #2;
    end
    cmd_valid = 0;
    rsp_ready = 1;
    repeat (6) @(posedge clk);
    #2;
    chk("rand_rsp_count", m_rsp_cnt > 200, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
